build_stamp_shifter: RTL

Parametrised successor to the fixed build-timestamp constant block. Packs the build identity fields (revision, subrevision, year, month, day, hour, minute) and an optional running uptime counter into one serial frame. The frame is read out through a virtual-JTAG-style capture/shift/update strobe interface, so host tools can read the build stamp and uptime and issue a simple command. It sits between the virtual JTAG instruction decode and the design's status logic.

---
 rtl/build_stamp_shifter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/build_stamp_shifter.sv
// Build-stamp and uptime frame, read out through a capture/shift/update strobe port.
// Optional feature macro: STAMP_UPTIME_EN builds the uptime counter, its prescaler and the 0xA5 clear command.
module build_stamp_shifter #(
    parameter int unsigned REVISION    = 70,
    parameter int unsigned SUBREVISION = 2,
    parameter int unsigned YEAR        = 23,
    parameter int unsigned MONTH       = 1,
    parameter int unsigned DAY         = 17,
    parameter int unsigned HOUR        = 18,
    parameter int unsigned MINUTE      = 12,
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned UPTIME_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cdr,
    input  logic                sdr,
    input  logic                udr,
    input  logic                tdi,
    output logic                tdo,
    output logic [UPTIME_W-1:0] uptime_s,
    output logic [7:0]          cmd_q
);

    localparam int unsigned STAMP_W = 38;

    localparam logic [STAMP_W-1:0] STAMP = {
        6'(MINUTE), 5'(HOUR), 5'(DAY), 4'(MONTH),
        7'(YEAR), 4'(SUBREVISION), 7'(REVISION)
    };

`ifdef STAMP_UPTIME_EN
    localparam int unsigned FRAME_W = STAMP_W + UPTIME_W;
`else
    localparam int unsigned FRAME_W = STAMP_W;
`endif

    if (CLK_HZ < 2 || UPTIME_W < 8) begin : g_bad_cfg
        $error("build_stamp_shifter: needs CLK_HZ >= 2 and UPTIME_W >= 8");
    end

    logic [FRAME_W-1:0] sr_q;
    logic [FRAME_W-1:0] sr_d;
    logic [FRAME_W-1:0] frame;
    logic [7:0]         cmd_d;
    logic               do_cap;
    logic               do_shift;
    logic               do_upd;

    // Capture beats shift, shift beats update.
    assign do_cap   = cdr;
    assign do_shift = sdr & ~cdr;
    assign do_upd   = udr & ~cdr & ~sdr;

    assign tdo = sr_q[0];

`ifdef STAMP_UPTIME_EN
    localparam int unsigned PRESC_W = $clog2(CLK_HZ);

    logic [PRESC_W-1:0]  presc_q;
    logic [PRESC_W-1:0]  presc_d;
    logic [UPTIME_W-1:0] uptime_q;
    logic [UPTIME_W-1:0] uptime_d;
    logic                tick;
    logic                clr;

    assign tick = (presc_q == PRESC_W'(CLK_HZ - 1));
    assign clr  = do_upd && (sr_q[FRAME_W-1 -: 8] == 8'hA5);

    // Seconds prescaler and uptime counter; the clear command wins over a tick.
    always_comb begin
        presc_d  = presc_q;
        uptime_d = uptime_q;
        if (clr) begin
            presc_d  = '0;
            uptime_d = '0;
        end else if (tick) begin
            presc_d  = '0;
            uptime_d = uptime_q + 1'b1;
        end else begin
            presc_d  = presc_q + 1'b1;
        end
    end

    // Uptime state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q  <= '0;
            uptime_q <= '0;
        end else begin
            presc_q  <= presc_d;
            uptime_q <= uptime_d;
        end
    end

    assign uptime_s = uptime_q;
    assign frame    = {uptime_q, STAMP};
`else
    assign uptime_s = '0;
    assign frame    = STAMP;
`endif

    // Shift register and command byte next-state.
    always_comb begin
        sr_d  = sr_q;
        cmd_d = cmd_q;
        unique case (1'b1)
            do_cap:   sr_d = frame;
            do_shift: sr_d = {tdi, sr_q[FRAME_W-1:1]};
            do_upd:   cmd_d = sr_q[FRAME_W-1 -: 8];
            default:  ;
        endcase
    end

    // Shift register and command byte state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cmd_q <= 8'h00;
        end else begin
            sr_q  <= sr_d;
            cmd_q <= cmd_d;
        end
    end

endmodule
